// File: rtl/mux4_to_1_pkg.sv
// Shared select encoding for the 4:1 selector and its 2:1 building block.
package mux4_to_1_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_X0 = 2'b00;
  localparam sel_t SEL_X1 = 2'b01;
  localparam sel_t SEL_X2 = 2'b10;
  localparam sel_t SEL_X3 = 2'b11;

endpackage : mux4_to_1_pkg

// File: rtl/mux4_to_1_mux2_to_1.sv
// WIDTH-parameterized 2:1 selector; an unknown select yields an all-X result.
module mux2_to_1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = 'x;
    case (sel_i)
      1'b0:    y_o = a_i;
      1'b1:    y_o = b_i;
      default: y_o = 'x;
    endcase
  end

endmodule : mux2_to_1

// File: rtl/mux4_to_1.sv
// 4:1 selector built as a 2:1 tree, with an enable-gated, async-cleared output register.
module mux4_to_1
  import mux4_to_1_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] X0,
  input  logic [WIDTH-1:0] X1,
  input  logic [WIDTH-1:0] X2,
  input  logic [WIDTH-1:0] X3,
  input  logic [1:0]       S,
  output logic [WIDTH-1:0] Z,
  output logic [WIDTH-1:0] Z_Q
);

  sel_t             sel;
  logic [WIDTH-1:0] lo_pair;
  logic [WIDTH-1:0] hi_pair;
  logic [WIDTH-1:0] z_d;
  logic [WIDTH-1:0] z_q;

  assign sel = S;

  // Level 1 resolves S[0] within each pair; level 2 picks the pair with S[1].
  mux2_to_1 #(.WIDTH(WIDTH)) u_mux_lo (
    .a_i   (X0),
    .b_i   (X1),
    .sel_i (sel[0]),
    .y_o   (lo_pair)
  );

  mux2_to_1 #(.WIDTH(WIDTH)) u_mux_hi (
    .a_i   (X2),
    .b_i   (X3),
    .sel_i (sel[0]),
    .y_o   (hi_pair)
  );

  mux2_to_1 #(.WIDTH(WIDTH)) u_mux_out (
    .a_i   (lo_pair),
    .b_i   (hi_pair),
    .sel_i (sel[1]),
    .y_o   (Z)
  );

  always_comb begin
    z_d = z_q;
    if (EN) begin
      z_d = Z;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  assign Z_Q = z_q;

endmodule : mux4_to_1

// File: tb/tb_mux4_to_1.sv
// Directed checks of the 4:1 selector: combinational path, register, enable and async reset.
module tb_mux4_to_1;
  import mux4_to_1_pkg::*;

  logic       CLK;
  logic       RST_N;
  logic       EN;
  logic [0:0] X0, X1, X2, X3;
  logic [1:0] S;
  logic [0:0] Z;
  logic [0:0] Z_Q;

  int unsigned total;
  int unsigned passed;
  int unsigned failed;

  mux4_to_1 #(.WIDTH(1)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .EN    (EN),
    .X0    (X0),
    .X1    (X1),
    .X2    (X2),
    .X3    (X3),
    .S     (S),
    .Z     (Z),
    .Z_Q   (Z_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic x0, input logic x1, input logic x2,
                       input logic x3, input sel_t s);
    X0 = x0; X1 = x1; X2 = x2; X3 = x3; S = s;
  endtask

  initial begin
    logic [5:0] vec;
    logic [3:0] data;
    total = 0; passed = 0; failed = 0;

    RST_N = 1'b0;
    EN    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, SEL_X0);
    #1;
    check("reset_z", Z, 1'b0);
    check("reset_zq", Z_Q, 1'b0);

    @(negedge CLK);
    RST_N = 1'b1;

    // Directed vectors from hand-worked expectations
    drive(1'b1, 1'b0, 1'b1, 1'b1, SEL_X1); #1;
    check("sel_x1_low", Z, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, SEL_X2); #1;
    check("sel_x2_high", Z, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, SEL_X2); #1;
    check("x0_no_effect", Z, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, SEL_X3); #1;
    check("sel_x3_low", Z, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, SEL_X0); #1;
    check("sel_x0_low", Z, 1'b0);
    check("zq_held_en0", Z_Q, 1'b0);

    // Exhaustive sweep of {X3,X2,X1,X0,S}
    for (int i = 0; i < 64; i++) begin
      vec  = 6'(i);
      data = vec[5:2];
      drive(data[0], data[1], data[2], data[3], vec[1:0]);
      #1;
      check($sformatf("sweep_%0d", i), Z, data[vec[1:0]]);
    end

    // Enabled load, then hold with EN low
    @(negedge CLK);
    EN = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b0, SEL_X2);
    @(posedge CLK); #1;
    check("zq_load", Z_Q, 1'b1);
    EN = 1'b0;
    X2 = 1'b0;
    #1;
    check("z_after_x2_low", Z, 1'b0);
    @(posedge CLK); #1;
    check("zq_hold", Z_Q, 1'b1);

    // Async clear away from any edge; Z unaffected
    @(negedge CLK);
    X2 = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    check("zq_async_clear", Z_Q, 1'b0);
    check("z_during_reset", Z, 1'b1);

    // EN ignored while in reset across an edge
    EN = 1'b1;
    @(posedge CLK); #1;
    check("zq_reset_ignores_en", Z_Q, 1'b0);

    // After release, stays 0 until an enabled edge
    @(negedge CLK);
    EN = 1'b0;
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("zq_post_reset_en0", Z_Q, 1'b0);
    EN = 1'b1;
    @(posedge CLK); #1;
    check("zq_first_enabled_edge", Z_Q, 1'b1);

    // Select change picked up on the next enabled edge
    drive(1'b0, 1'b1, 1'b1, 1'b1, SEL_X0);
    #1;
    check("zq_one_cycle_latency", Z_Q, 1'b1);
    @(posedge CLK); #1;
    check("zq_follows_x0", Z_Q, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish within 100000");
    $fatal(1, "timeout");
  end

endmodule : tb_mux4_to_1
